// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
// FSM encodings and the default reset PC.
package if_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } if_state_e;

   localparam int unsigned IF_RESET_PC = 0;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: valid, instruction and pc+1.
// clr drops only the valid bit; the payload is left as is.
module ifid_reg #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               clr,
   input  logic [INSTR_W-1:0] d_instr,
   input  logic [ADDR_W-1:0]  d_pc1,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pc1
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         instr <= '0;
         pc1   <= '0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= d_instr;
         pc1   <= d_pc1;
      end else if (clr) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, instruction-memory request FSM and IF/ID hand-off.
// HOLD parks a fetched word while decode stalls; DROP eats a stale ack.
module pc_fetch_unit
   import if_pkg::*;
#(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned INSTR_W  = 32,
   parameter int unsigned RESET_PC = IF_RESET_PC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDR_W-1:0]  pc_next,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  pc_plus1,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               flush,
   input  logic               ifid_ready,
   output logic               ifid_valid,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0]  ifid_pc1
);

   localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

   if_state_e          state;
   logic [ADDR_W-1:0]  req_addr;
   logic [INSTR_W-1:0] hold_instr;
   logic [ADDR_W-1:0]  hold_pc1;

   logic               ack_v;
   logic               slot_free;
   logic               ld;
   logic               clr;
   logic [INSTR_W-1:0] d_instr;
   logic [ADDR_W-1:0]  d_pc1;

   assign pc_plus1  = pc + ADDR_W'(1);
   assign imem_addr = req_addr;
   // an ack with no request outstanding is ignored
   assign ack_v     = imem_ack & imem_req;
   assign slot_free = ~ifid_valid | ifid_ready;

   always_comb begin
      ld      = 1'b0;
      clr     = 1'b0;
      d_instr = imem_rdata;
      d_pc1   = pc_plus1;
      unique case (state)
         FETCH: begin
            if (flush)
               clr = 1'b1;
            else if (ack_v && slot_free)
               ld = 1'b1;
            else if (ifid_ready)
               clr = 1'b1;
         end
         HOLD: begin
            if (flush) begin
               clr = 1'b1;
            end else if (ifid_ready) begin
               ld      = 1'b1;
               d_instr = hold_instr;
               d_pc1   = hold_pc1;
            end
         end
         DROP: begin
            if (flush || ifid_ready)
               clr = 1'b1;
         end
         default: clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FETCH;
         pc         <= RST_PC;
         req_addr   <= RST_PC;
         imem_req   <= 1'b0;
         hold_instr <= '0;
         hold_pc1   <= '0;
      end else begin
         unique case (state)
            FETCH: begin
               imem_req <= 1'b1;
               if (flush) begin
                  pc <= pc_next;
                  if (ack_v || !imem_req)
                     req_addr <= pc_next;
                  else
                     state <= DROP;
               end else if (ack_v) begin
                  pc       <= pc_next;
                  req_addr <= pc_next;
                  if (!slot_free) begin
                     hold_instr <= imem_rdata;
                     hold_pc1   <= pc_plus1;
                     state      <= HOLD;
                     imem_req   <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (flush) begin
                  pc         <= pc_next;
                  req_addr   <= pc_next;
                  hold_instr <= '0;
                  hold_pc1   <= '0;
                  state      <= FETCH;
                  imem_req   <= 1'b1;
               end else if (ifid_ready) begin
                  state    <= FETCH;
                  imem_req <= 1'b1;
               end
            end
            DROP: begin
               imem_req <= 1'b1;
               if (flush) begin
                  pc <= pc_next;
                  if (ack_v) begin
                     req_addr <= pc_next;
                     state    <= FETCH;
                  end
               end else if (ack_v) begin
                  req_addr <= pc;
                  state    <= FETCH;
               end
            end
            default: begin
               state    <= FETCH;
               imem_req <= 1'b1;
            end
         endcase
      end
   end

   ifid_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_ifid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (ld),
      .clr     (clr),
      .d_instr (d_instr),
      .d_pc1   (d_pc1),
      .valid   (ifid_valid),
      .instr   (ifid_instr),
      .pc1     (ifid_pc1)
   );

endmodule
